bcd4_to_bin: RTL and testbench
==============================

// Module: bcd4_to_bin
// PURPOSE
//   Sequential 4-digit BCD to binary converter; inverse of the binary-to-BCD display path.
//   Converts keypad/switch-entered digits back to a binary count for the counter/compare logic.
//   Uses reverse double-dabble: shift right, then subtract 3 from every digit >= 8.
//   Start/ready handshake, one conversion at a time.
// PARAMETERS
//   VALUE_W   14   binary result width; must be >= 14 (9999 max); MSBs above bit 13 always 0
// PORTS
//   clk    in   1        system clock, rising edge
//   rst    in   1        asynchronous, active-low reset (0 = reset, 1 = run)
//   A      in   4        thousands digit (BCD), sampled on accepted start
//   B      in   4        hundreds digit
//   C      in   4        tens digit
//   D      in   4        ones digit
//   start  in   1        conversion request; accepted only while ready=1
//   ready  out  1        1 = idle, value valid (after first conversion)
//   value  out  VALUE_W  binary result, registered, held until next completion
//   err    out  1        invalid digit flag (see CONFIGURATION)
// BEHAVIOUR
//   Reset (rst=0, async): state=IDLE, ready=1, value=0, err=0, count=0, work regs=0.
//   States: IDLE -> SHIFT -> IDLE.
//   IDLE: ready=1. start=1 at edge E0 -> load work reg {A,B,C,D, VALUE_W'b0}, count=0,
//     err=0, state=SHIFT, ready=0 from E0.
//   SHIFT: each edge shifts the 16+VALUE_W work reg right 1, then each 4-bit BCD digit
//     >= 8 gets 3 subtracted (4-bit, no borry across digits). count++.
//   After the VALUE_W-th shift (edge E_VALUE_W; E14 by default): value <= low VALUE_W
//     bits, ready=1, state=IDLE. Latency = VALUE_W cycles from the start edge.
//   start while ready=0 is ignored, not queued. Digit inputs may change after E0.
//   start held high continuously: a new conversion begins on the edge after ready rises.
//   value changes only at completion; it keeps the previous result during SHIFT.
//   rst low mid-conversion: abort immediately, all outputs to reset values.
//   Arithmetic: result = 1000*A + 100*B + 10*C + D for valid digits; no overflow possible.
// CONFIGURATION
//   BCD4_TO_BIN_CHECK_EN defined: at E0 any digit > 9 -> err=1, value=0, ready stays 1,
//     no SHIFT; err clears on the next accepted start with valid digits or on reset.
//   Not defined: no check; err tied 0; invalid digits run the normal algorithm and the
//     result is the algorithm's output truncated to VALUE_W bits (not specified further).
// STRUCTURE
//   Package bcd_pkg: state encoding (ST_IDLE, ST_SHIFT), BCD_W=4, BCD_DIGITS=4,
//     BCD_MAX=4'd9, BCD_CORR_THRESH=4'd8, BCD_CORR=4'd3.
//   Sub-module bcd_digit_corr: combinational, 4b in -> (in >= 8) ? in-3 : in;
//     instantiated 4x on the post-shift digit fields.
//   Top: FSM, ceil(log2(VALUE_W+1))-bit counter, work shift register, output regs.
// TESTING
//   A,B,C,D=4,9,3,4, start 1 cycle -> ready low 14 cycles, then value=4934, ready=1.
//   Digits 0,0,0,0 -> value=0; digits 9,9,9,9 -> value=9999 (14'h270F), 14 cycles.
//   Convert 1,2,3,4 then pulse start at cycle 5 with 5,6,7,8 -> ignored, value=1234.
//   rst=0 at cycle 7 of a conversion -> ready=1, value=0 same cycle; new start works.
//   CHECK_EN: A=4'hA -> err=1, value=0, ready stays 1; next start 0,0,1,0 -> err=0, value=10.
//   Back-to-back: start held high with 0,0,4,2 -> value=42 every 15 cycles, ready pulses.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared constants and state encoding for the 4-digit BCD to binary converter.
package bcd_pkg;

  localparam int unsigned BCD_W      = 4;
  localparam int unsigned BCD_DIGITS = 4;

  localparam logic [BCD_W-1:0] BCD_MAX         = 4'd9;
  localparam logic [BCD_W-1:0] BCD_CORR_THRESH = 4'd8;
  localparam logic [BCD_W-1:0] BCD_CORR        = 4'd3;

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_SHIFT
  } state_e;

  function automatic logic bcd_digit_bad(input logic [BCD_W-1:0] digit);
    return digit > BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit_corr.sv
// Reverse double-dabble digit correction: subtract 3 from a BCD digit field that is >= 8.
module bcd_digit_corr
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] digit_i,
  output logic [BCD_W-1:0] digit_o
);

  assign digit_o = (digit_i >= BCD_CORR_THRESH) ? digit_i - BCD_CORR : digit_i;

endmodule

// File: rtl/bcd4_to_bin.sv
// Sequential 4-digit BCD to binary converter (reverse double-dabble), start/ready handshake.
// Define BCD4_TO_BIN_CHECK_EN to reject digits > 9 at start with the err flag.
module bcd4_to_bin
  import bcd_pkg::*;
#(
  parameter int unsigned VALUE_W = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [BCD_W-1:0]   A,
  input  logic [BCD_W-1:0]   B,
  input  logic [BCD_W-1:0]   C,
  input  logic [BCD_W-1:0]   D,
  input  logic               start,
  output logic               ready,
  output logic [VALUE_W-1:0] value,
  output logic               err
);

  localparam int unsigned CNT_W  = $clog2(VALUE_W + 1);
  localparam int unsigned DIG_W  = BCD_W * BCD_DIGITS;
  localparam int unsigned WORK_W = DIG_W + VALUE_W;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(VALUE_W - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [WORK_W-1:0]  work_q, work_d;
  logic [VALUE_W-1:0] value_q, value_d;
  logic               err_q, err_d;

  logic [WORK_W-1:0]  shifted;
  logic [DIG_W-1:0]   corr_digits;
  logic               digits_bad;

`ifdef BCD4_TO_BIN_CHECK_EN
  assign digits_bad = bcd_digit_bad(A) | bcd_digit_bad(B) | bcd_digit_bad(C) | bcd_digit_bad(D);
`else
  // Without the check err can never be set, so it is constant 0.
  assign digits_bad = 1'b0;
`endif

  assign shifted = work_q >> 1;

  for (genvar i = 0; i < BCD_DIGITS; i++) begin : g_corr
    bcd_digit_corr u_corr (
      .digit_i(shifted[VALUE_W + i*BCD_W +: BCD_W]),
      .digit_o(corr_digits[i*BCD_W +: BCD_W])
    );
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    work_d  = work_q;
    value_d = value_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (digits_bad) begin
            err_d   = 1'b1;
            value_d = '0;
          end else begin
            work_d  = {A, B, C, D, {VALUE_W{1'b0}}};
            count_d = '0;
            err_d   = 1'b0;
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        // Binary bits enter from the top of the low field; after VALUE_W shifts it is complete.
        work_d  = {corr_digits, shifted[VALUE_W-1:0]};
        count_d = count_q + CNT_W'(1);
        if (count_q == LAST_CNT) begin
          value_d = work_d[VALUE_W-1:0];
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      work_q  <= '0;
      value_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      work_q  <= work_d;
      value_q <= value_d;
      err_q   <= err_d;
    end
  end

  assign ready = (state_q == ST_IDLE);
  assign value = value_q;
  assign err   = err_q;

endmodule

// File: tb/tb_bcd4_to_bin.sv
// Self-checking bench for bcd4_to_bin: directed cases plus randomized digits vs. arithmetic model.
module tb_bcd4_to_bin;

  localparam int unsigned VALUE_W = 14;
  localparam int unsigned LAT     = VALUE_W;

  logic               clk;
  logic               rst;
  logic [3:0]         a, b, c, d;
  logic               start;
  logic               ready;
  logic [VALUE_W-1:0] value;
  logic               err;

  int n_cmp;
  int n_bad;
  int prev_exp;

  bcd4_to_bin #(.VALUE_W(VALUE_W)) dut (
    .clk  (clk),
    .rst  (rst),
    .A    (a),
    .B    (b),
    .C    (c),
    .D    (d),
    .start(start),
    .ready(ready),
    .value(value),
    .err  (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ref_val(input int da, input int db, input int dc, input int dd);
    return 1000 * da + 100 * db + 10 * dc + dd;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One conversion; pulse_at (1..13) drives an extra start with other digits mid-conversion.
  task automatic run_conv(input string tag, input int da, input int db, input int dc,
                          input int dd, input int pulse_at);
    int n;
    int expv;
    expv = ref_val(da, db, dc, dd);
    @(negedge clk);
    a = 4'(da); b = 4'(db); c = 4'(dc); d = 4'(dd);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    @(negedge clk);
    while (!ready && n < 40) begin
      n++;
      if (n == 1) check({tag, "_hold"}, 32'(value), 32'(prev_exp));
      if (pulse_at != 0 && n == pulse_at) begin
        start = 1'b1;
        a = 4'($urandom_range(9)); b = 4'($urandom_range(9));
        c = 4'($urandom_range(9)); d = 4'($urandom_range(9));
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, "_lat"}, 32'(n), 32'(LAT));
    check({tag, "_val"}, 32'(value), 32'(expv));
    check({tag, "_err"}, 32'(err), 32'd0);
    @(negedge clk);
    check({tag, "_noq"}, 32'(ready), 32'd1);
    prev_exp = expv;
  endtask

  initial begin
    int lo;
    int hi;
    n_cmp    = 0;
    n_bad    = 0;
    prev_exp = 0;
    rst   = 1'b0;
    start = 1'b0;
    a = 4'd0; b = 4'd0; c = 4'd0; d = 4'd0;

    repeat (3) @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_value", 32'(value), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst = 1'b1;

    run_conv("c4934", 4, 9, 3, 4, 0);
    run_conv("c0000", 0, 0, 0, 0, 0);
    run_conv("c9999", 9, 9, 9, 9, 0);
    run_conv("c1234_ign", 1, 2, 3, 4, 5);

    // Abort mid-conversion with asynchronous reset.
    @(negedge clk);
    a = 4'd9; b = 4'd8; c = 4'd7; d = 4'd6;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (7) @(negedge clk);
    check("abort_busy", 32'(ready), 32'd0);
    #1 rst = 1'b0;
    #1;
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_value", 32'(value), 32'd0);
    check("abort_err", 32'(err), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    prev_exp = 0;
    run_conv("after_abort", 4, 9, 3, 4, 0);

`ifdef BCD4_TO_BIN_CHECK_EN
    @(negedge clk);
    a = 4'hA; b = 4'd0; c = 4'd0; d = 4'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("chk_err", 32'(err), 32'd1);
    check("chk_value", 32'(value), 32'd0);
    check("chk_ready", 32'(ready), 32'd1);
    prev_exp = 0;
    run_conv("chk_recover", 0, 0, 1, 0, 0);
`endif

    // Back-to-back with start held high.
    @(negedge clk);
    a = 4'd0; b = 4'd0; c = 4'd4; d = 4'd2;
    start = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      lo = 0;
      while (!ready && lo < 40) begin
        lo++;
        @(negedge clk);
      end
      check("b2b_low", 32'(lo), 32'(LAT));
      check("b2b_val", 32'(value), 32'd42);
      hi = 0;
      while (ready && hi < 40) begin
        hi++;
        @(negedge clk);
      end
      check("b2b_high", 32'(hi), 32'd1);
    end
    start = 1'b0;
    lo = 0;
    while (!ready && lo < 40) begin
      lo++;
      @(negedge clk);
    end
    check("b2b_drain", 32'(value), 32'd42);
    prev_exp = 42;

    for (int i = 0; i < 20; i++) begin
      run_conv("rand", int'($urandom_range(9)), int'($urandom_range(9)),
               int'($urandom_range(9)), int'($urandom_range(9)),
               (i % 2 == 0) ? 0 : int'($urandom_range(13, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
